io_tx_buffer: RTL and testbench

- Sits directly downstream of the cpu top on its memory bus, between cpu and the hci/UART.
- Captures cpu writes to I/O addresses 0x30000 (byte out) and 0x30004 (program stop) into a small FIFO.
- Drains them to the hci one write at a time, honouring io_buffer_full.
- Gives the cpu a stall signal so no I/O byte is lost while the UART is backed up.

---
 rtl/io_tx_buffer.sv | 142 ++++++++++++++
 tb/tb_io_tx_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_tx_buffer.sv
// io_tx_buffer: queues cpu writes to I/O addresses 0x30000/0x30004 and replays them to the hci one at a time.
// Optional IO_TX_BYPASS_EN: an idle, empty buffer forwards a qualifying push straight to the hci (latency 1).
module io_tx_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [31:0]           cpu_a,
    input  logic [DATA_WIDTH-1:0] cpu_dout,
    input  logic                  cpu_wr,
    output logic                  cpu_io_stall,
    output logic [31:0]           hci_a,
    output logic [DATA_WIDTH-1:0] hci_dout,
    output logic                  hci_wr,
    input  logic                  io_buffer_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, STOPPED} state_e;

    typedef struct packed {
        logic                  stop;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CW-1:0]         count_q;
    state_e                state_q;
    logic                  hci_wr_q;
    logic [31:0]           hci_a_q;
    logic [DATA_WIDTH-1:0] hci_dout_q;
    logic                  issued_stop_q;
    logic                  overflow_q;

    logic   addr_hit;
    logic   is_stop;
    logic   push_valid;
    logic   full;
    logic   can_pop;
    logic   bypass;
    logic   push_store;
    logic   issue_go;
    entry_t push_entry;
    entry_t issue_entry;
    logic   unused_addr_bits;

    // Only a[17:16] and a[2:0] decode the I/O window; the remaining address bits are don't-care.
    assign addr_hit         = (cpu_a[17:16] == 2'b11) && (cpu_a[1:0] == 2'b00);
    assign is_stop          = cpu_a[2];
    assign unused_addr_bits = ^{cpu_a[31:18], cpu_a[15:3]};

    assign push_valid = rdy_in && cpu_wr && addr_hit && (is_stop || (cpu_dout != '0));
    assign push_entry = '{stop: is_stop, data: (is_stop ? '0 : cpu_dout)};

    assign full    = (count_q == CW'(DEPTH));
    assign can_pop = rdy_in && (count_q != '0) && !io_buffer_full &&
                     ((state_q == IDLE) || (state_q == GAP));

`ifdef IO_TX_BYPASS_EN
    assign bypass = push_valid && (state_q == IDLE) && (count_q == '0) && !io_buffer_full;
`else
    assign bypass = 1'b0;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_store  = push_valid && !bypass && (!full || can_pop);
    assign issue_go    = can_pop || bypass;
    assign issue_entry = bypass ? push_entry : mem_q[rd_ptr_q];

    assign cpu_io_stall = (count_q >= CW'(DEPTH - 1));
    assign hci_wr       = hci_wr_q && rdy_in;
    assign hci_a        = hci_a_q;
    assign hci_dout     = hci_dout_q;
    assign fifo_count   = count_q;
    assign overflow_err = overflow_q;

    // NOTE: payload storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (push_store) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // NOTE: every register here uses <= so all next-state terms see the values from before the edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            hci_wr_q      <= 1'b0;
            hci_a_q       <= '0;
            hci_dout_q    <= '0;
            issued_stop_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (rdy_in) begin
            if (push_store) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (can_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_store) - CW'(can_pop);
            if (push_valid && full && !can_pop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE, GAP: begin
                    if (issue_go) begin
                        hci_wr_q      <= 1'b1;
                        hci_a_q       <= issue_entry.stop ? 32'h0003_0004 : 32'h0003_0000;
                        hci_dout_q    <= issue_entry.data;
                        issued_stop_q <= issue_entry.stop;
                        state_q       <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    hci_wr_q <= 1'b0;
                    state_q  <= issued_stop_q ? STOPPED : GAP;
                end
                STOPPED: begin
                    hci_wr_q <= 1'b0;
                end
                default: begin
                    hci_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_tx_buffer.sv
// Self-checking bench for io_tx_buffer: directed scenarios plus a randomized phase against a queue-based model.
module tb_io_tx_buffer;
    localparam int DL2   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << DL2;
`ifdef IO_TX_BYPASS_EN
    localparam int LAT   = 1;
    localparam int PEAK1 = 0;
`else
    localparam int LAT   = 2;
    localparam int PEAK1 = 1;
`endif

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic           rdy_in = 1'b1;
    logic [31:0]    cpu_a = '0;
    logic [DW-1:0]  cpu_dout = '0;
    logic           cpu_wr = 1'b0;
    logic           io_buffer_full = 1'b0;
    logic           cpu_io_stall;
    logic [31:0]    hci_a;
    logic [DW-1:0]  hci_dout;
    logic           hci_wr;
    logic [DL2:0]   fifo_count;
    logic           overflow_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int peak   = 0;

    typedef struct {
        logic [31:0]   a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];

    io_tx_buffer #(.DEPTH_LOG2(DL2), .DATA_WIDTH(DW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .cpu_a         (cpu_a),
        .cpu_dout      (cpu_dout),
        .cpu_wr        (cpu_wr),
        .cpu_io_stall  (cpu_io_stall),
        .hci_a         (hci_a),
        .hci_dout      (hci_dout),
        .hci_wr        (hci_wr),
        .io_buffer_full(io_buffer_full),
        .fifo_count    (fifo_count),
        .overflow_err  (overflow_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Collect every hci write and the occupancy high-water mark, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (hci_wr === 1'b1) obs_q.push_back('{hci_a, hci_dout, cyc});
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: decode on a[17:16] and a[2:0]; zero bytes vanish; stops carry data 0.
    task automatic model_push(input logic [31:0] a, input logic [DW-1:0] d);
        wr_t e;
        if (rdy_in && a[17:16] == 2'b11) begin
            if (a[2:0] == 3'b100) begin
                e = '{32'h0003_0004, '0, 0};
                exp_q.push_back(e);
            end else if (a[2:0] == 3'b000 && d != '0) begin
                e = '{32'h0003_0000, d, 0};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic write_cycle(input logic [31:0] a, input logic [DW-1:0] d);
        cpu_a    = a;
        cpu_dout = d;
        cpu_wr   = 1'b1;
        model_push(a, d);
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int limit);
        int k = 0;
        while (obs_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        check("drain_timeout", 64'(obs_q.size() >= n), 64'd1);
    endtask

    task automatic compare_n(input string tag, input int n);
        wr_t e;
        wr_t o;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = '{32'hFFFF_FFFF, '1, -1};
            check({tag, "_addr"}, 64'(o.a), 64'(e.a));
            check({tag, "_data"}, 64'(o.d), 64'(e.d));
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        obs_q.delete();
        exp_q.delete();
        tick();
    endtask

    initial begin
        int  n0;
        int  r;
        bit  found;
        logic [31:0] a;
        logic [DW-1:0] d;

        // Reset state
        tick();
        tick();
        check("rst_hci_wr", 64'(hci_wr), 64'd0);
        check("rst_hci_a", 64'(hci_a), 64'd0);
        check("rst_hci_dout", 64'(hci_dout), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        check("rst_stall", 64'(cpu_io_stall), 64'd0);
        rst_in = 1'b1;
        tick();
        tick();

        // Two back-to-back bytes: latency and pulse spacing
        n0 = cyc;
        write_cycle(32'h0003_0000, 8'h48);
        write_cycle(32'h0003_0000, 8'h69);
        wait_obs(2, 20);
        if (obs_q.size() >= 2) begin
            check("lat_first", 64'(obs_q[0].c), 64'(n0 + LAT));
            check("lat_second", 64'(obs_q[1].c), 64'(n0 + LAT + 2));
        end
        compare_n("hi", 2);
        repeat (4) tick();

        // Zero byte discarded
        peak = 0;
        write_cycle(32'h0003_0000, 8'h00);
        write_cycle(32'h0003_0000, 8'h41);
        wait_obs(1, 20);
        compare_n("zero", 1);
        repeat (4) tick();
        check("zero_extra", 64'(obs_q.size()), 64'd0);
        check("zero_peak", 64'(peak), 64'(PEAK1));

        // Fill while blocked, stall threshold, overflow, then ordered drain
        io_buffer_full = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            write_cycle(32'h0003_0000, 8'($urandom_range(1, 255)));
            if (i == DEPTH - 3) begin
                check("stall_low_cnt", 64'(fifo_count), 64'(DEPTH - 2));
                check("stall_low", 64'(cpu_io_stall), 64'd0);
            end
            if (i == DEPTH - 2) begin
                check("stall_high_cnt", 64'(fifo_count), 64'(DEPTH - 1));
                check("stall_high", 64'(cpu_io_stall), 64'd1);
            end
        end
        check("full_ovf_pre", 64'(overflow_err), 64'd0);
        cpu_a = 32'h0003_0000;
        cpu_dout = 8'hEE;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        check("full_ovf", 64'(overflow_err), 64'd1);
        check("full_cnt", 64'(fifo_count), 64'(DEPTH));
        io_buffer_full = 1'b0;
        wait_obs(DEPTH, 80);
        compare_n("full_drain", DEPTH);
        repeat (3) tick();
        check("full_empty", 64'(fifo_count), 64'd0);
        check("ovf_sticky", 64'(overflow_err), 64'd1);

        // rdy_in low freezes everything
        io_buffer_full = 1'b1;
        write_cycle(32'h0003_0000, 8'h55);
        write_cycle(32'h0003_0000, 8'hAA);
        check("rdy_cnt", 64'(fifo_count), 64'd2);
        rdy_in = 1'b0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_hold_cnt", 64'(fifo_count), 64'd2);
            check("rdy_hold_wr", 64'(hci_wr), 64'd0);
        end
        check("rdy_no_obs", 64'(obs_q.size()), 64'd0);
        rdy_in = 1'b1;
        r = cyc;
        wait_obs(2, 20);
        if (obs_q.size() >= 1) check("rdy_resume", 64'(obs_q[0].c), 64'(r + 1));
        compare_n("rdy", 2);
        repeat (3) tick();

        // Asynchronous reset while a write is being issued
        io_buffer_full = 1'b1;
        write_cycle(32'h0003_0000, 8'h11);
        write_cycle(32'h0003_0000, 8'h22);
        write_cycle(32'h0003_0000, 8'h33);
        io_buffer_full = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (hci_wr === 1'b1) found = 1'b1;
        end
        check("issue_seen", 64'(found), 64'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_wr", 64'(hci_wr), 64'd0);
        check("arst_cnt", 64'(fifo_count), 64'd0);
        check("arst_ovf", 64'(overflow_err), 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        obs_q.delete();
        exp_q.delete();
        tick();

        // Stop entry ends draining for good
        write_cycle(32'h0003_0000, 8'h31);
        write_cycle(32'h0003_0004, 8'h77);
        write_cycle(32'h0003_0000, 8'h32);
        wait_obs(2, 20);
        compare_n("stop", 2);
        repeat (10) tick();
        check("stop_silent", 64'(obs_q.size()), 64'd0);
        check("stop_cnt", 64'(fifo_count), 64'(exp_q.size()));
        write_cycle(32'h0003_0000, 8'h33);
        repeat (4) tick();
        check("stop_cnt2", 64'(fifo_count), 64'(exp_q.size()));
        check("stop_silent2", 64'(obs_q.size()), 64'd0);

        // Randomized traffic, including decoys and zero bytes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            io_buffer_full = ($urandom_range(0, 3) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if (!cpu_io_stall && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(0, 255));
                a = {14'($urandom), 2'b11, 13'($urandom), 3'b000};
                case ($urandom_range(0, 7))
                    4: a[2:0] = 3'b010;
                    5: a[17:16] = 2'b10;
                    6: a[2:0] = 3'b001;
                    7: d = '0;
                    default: ;
                endcase
                cpu_a = a;
                cpu_dout = d;
                cpu_wr = 1'b1;
                model_push(a, d);
            end else begin
                cpu_wr = 1'b0;
            end
            tick();
        end
        cpu_wr = 1'b0;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        wait_obs(exp_q.size(), 200);
        compare_n("rand", exp_q.size());
        repeat (4) tick();
        check("rand_extra", 64'(obs_q.size()), 64'd0);
        check("rand_cnt", 64'(fifo_count), 64'd0);
        check("rand_ovf", 64'(overflow_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
